// File: rtl/booth_mult_seq.sv
// ----------------------------------------------------------------------------
// booth_mult_seq
//   Sequential signed radix-4 (modified Booth) multiplier for the ALU mult
//   path. Two multiplier bits are retired per RUN cycle, so a WIDTH-bit
//   multiply takes WIDTH/2 RUN cycles. The result is the full, exact signed
//   2*WIDTH-bit product, split into upper and lower halves.
//
//   Optional feature macro: MULT_OVF_EN
//     defined   : data_exception is registered with the result and flags a
//                 product that does not fit in WIDTH signed bits.
//     undefined : data_exception is tied to 0.
//
// Ports
//   clock           in   1      rising-edge clock
//   reset           in   1      synchronous, active-high
//   ctrl_mult       in   1      start pulse; operands are sampled this cycle
//   data_operandA   in   WIDTH  multiplicand, two's complement
//   data_operandB   in   WIDTH  multiplier, two's complement
//   data_upper      out  WIDTH  product[2W-1:W]
//   data_result     out  WIDTH  product[W-1:0]
//   data_resultRDY  out  1      one-cycle pulse while the result is fresh
//   busy            out  1      high while iterating
//   data_exception  out  1      signed overflow of the product into W bits
//
// WIDTH must be even and at least 4.
// ----------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_upper,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy,
  output logic             data_exception
);

  localparam int ITER  = WIDTH / 2;
  localparam int CNT_W = $clog2(ITER + 1);
  // Two guard bits: the accumulator must hold acc +/- 2M without wrapping.
  localparam int AW    = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  m_q, m_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  q1_q, q1_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      upper_q, upper_d;
  logic [WIDTH-1:0]      lower_q, lower_d;
  logic                  exc_q, exc_d;

  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  acc_sh;
  logic [WIDTH-1:0]      q_sh;
  logic                  last_step;

  // Booth digit from {Q[1],Q[0],q_1} selects 0, +-M or +-2M.
  function automatic logic signed [AW-1:0] booth_addend(
    input logic [2:0]           sel,
    input logic signed [AW-1:0] m
  );
    logic signed [AW-1:0] m2;
    m2 = m <<< 1;
    case (sel)
      3'b001, 3'b010: return m;
      3'b011:         return m2;
      3'b100:         return -m2;
      3'b101, 3'b110: return -m;
      default:        return '0;
    endcase
  endfunction

  // One iteration: add the selected multiple, then shift {acc,Q,q_1}
  // arithmetically right by two.
  always_comb begin
    sum       = acc_q + booth_addend({q_q[1:0], q1_q}, m_q);
    acc_sh    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_sh      = {sum[1:0], q_q[WIDTH-1:2]};
    last_step = (cnt_q == CNT_W'(ITER - 1));
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    upper_d = upper_q;
    lower_d = lower_q;
    exc_d   = exc_q;

    if (ctrl_mult) begin
      // A start in any state (including mid-RUN abort and DONE back-to-back)
      // reloads the operands and restarts the iteration count.
      state_d = RUN;
      m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      acc_d   = '0;
      q_d     = data_operandB;
      q1_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          acc_d = acc_sh;
          q_d   = q_sh;
          q1_d  = q_q[1];
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            // After the final shift {acc[W-1:0],Q} is the 2W-bit product.
            state_d = DONE;
            upper_d = acc_sh[WIDTH-1:0];
            lower_d = q_sh;
            exc_d   = (acc_sh[WIDTH-1:0] != {WIDTH{q_sh[WIDTH-1]}});
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      exc_q   <= exc_d;
    end
  end

  assign data_upper     = upper_q;
  assign data_result    = lower_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

`ifdef MULT_OVF_EN
  assign data_exception = exc_q;
`else
  logic unused_exc;
  assign unused_exc     = exc_q;
  assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// ----------------------------------------------------------------------------
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq (WIDTH=32): directed vector table,
//   hand-written abort / reset / back-to-back sequences, and a randomized
//   scoreboard against a plain 64-bit signed multiply.
// ----------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int W       = 32;
  localparam int LAT     = W / 2 + 1;
  localparam int TIMEOUT = 60;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_mult;
  logic [W-1:0]  data_operandA;
  logic [W-1:0]  data_operandB;
  logic [W-1:0]  data_upper;
  logic [W-1:0]  data_result;
  logic          data_resultRDY;
  logic          busy;
  logic          data_exception;

  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_upper     (data_upper),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    logic           exc_en;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  function automatic logic ref_exc(input logic [63:0] p);
`ifdef MULT_OVF_EN
    return (p[63:32] != {32{p[31]}});
`else
    return 1'b0;
`endif
  endfunction

  // Issue a start. If from_done, the caller is at the falling edge of a DONE
  // cycle and the start rides in that cycle; otherwise one idle cycle first.
  // Returns at the falling edge of the RDY cycle (or after the timeout).
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic from_done, input logic [63:0] exp_p, input logic exp_x);
    int k;
    if (!from_done) @(negedge clock);
    ctrl_mult     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    k = 1;
    while (!data_resultRDY && k < TIMEOUT) begin
      @(negedge clock);
      k++;
    end
    chk({name, " latency"}, 64'(k), 64'(LAT));
    chk({name, " product"}, {data_upper, data_result}, exp_p);
    chk({name, " exc"}, 64'(data_exception), 64'(exp_x));
  endtask

  initial begin
    int rdy_cnt;
    int rdy_cyc;
    logic [63:0] p;
    logic [W-1:0] ra, rb;

    vecs[0] = '{32'd7,        32'd3,        64'h00000000_00000015, 1'b0};
    vecs[1] = '{32'hFFFFFFFB, 32'd6,        64'hFFFFFFFF_FFFFFFE2, 1'b0};
    vecs[2] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'd2,        64'h00000000_FFFFFFFE, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
    vecs[5] = '{32'h80000000, 32'd1,        64'hFFFFFFFF_80000000, 1'b0};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1};
    vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b1};
    vecs[8] = '{32'd0,        32'h12345678, 64'h00000000_00000000, 1'b0};
    vecs[9] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, 1'b1};

    reset = 1'b1;
    ctrl_mult = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset rdy", 64'(data_resultRDY), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset product", {data_upper, data_result}, 64'd0);
    chk("reset exc", 64'(data_exception), 64'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
`ifdef MULT_OVF_EN
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].prod, vecs[i].exc_en);
`else
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].prod, 1'b0);
`endif
    end
    @(negedge clock);
    chk("rdy one cycle", 64'(data_resultRDY), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);

    // Abort: start 9*9, restart with 4*-4 at cycle 5; single RDY at cycle 22.
    @(negedge clock);
    ctrl_mult = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    rdy_cnt = 0; rdy_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      ctrl_mult = 1'b0;
      if (c == 1) chk("abort busy c1", 64'(busy), 64'd1);
      if (c == 3) chk("hold during run", {data_upper, data_result}, vecs[9].prod);
      if (c == 5) begin
        ctrl_mult = 1'b1; data_operandA = 32'd4; data_operandB = 32'hFFFFFFFC;
      end
      if (data_resultRDY) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          chk("abort product", {data_upper, data_result}, 64'hFFFFFFFF_FFFFFFF0);
        end
      end
    end
    chk("abort rdy count", 64'(rdy_cnt), 64'd1);
    chk("abort rdy cycle", 64'(rdy_cyc), 64'd22);

    // Reset during RUN at cycle 8.
    @(negedge clock);
    ctrl_mult = 1'b1; data_operandA = 32'd11; data_operandB = 32'd13;
    rdy_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      ctrl_mult = 1'b0;
      if (c == 8) reset = 1'b1;
      if (c == 9) begin
        reset = 1'b0;
        chk("midrun reset busy", 64'(busy), 64'd0);
        chk("midrun reset product", {data_upper, data_result}, 64'd0);
      end
      if (data_resultRDY) rdy_cnt++;
    end
    chk("midrun reset no rdy", 64'(rdy_cnt), 64'd0);
    do_op("post reset 2*3", 32'd2, 32'd3, 1'b0, 64'd6, 1'b0);

    // Back-to-back from DONE: RDY for 2*3 was just seen, start -7*-9 now.
    do_op("b2b", 32'hFFFFFFF9, 32'hFFFFFFF7, 1'b1, 64'd63, 1'b0);

    // Randomized scoreboard, mixing idle starts and back-to-back starts.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = 32'h80000000; rb = $urandom; end
        1:       begin ra = $urandom; rb = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom)}; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      p = ref_prod(ra, rb);
      do_op("random", ra, rb, 1'($urandom_range(0, 1)), p, ref_exc(p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
